dram_latency_model: RTL and testbench

//  Word-addressed data memory slave on the DLX data-memory side (DRAM_* port group).

---
 rtl/dram_latency_model.sv | 138 +++++++++++++
 tb/tb_dram_latency_model.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/dram_latency_model.sv
// Word-addressed data memory slave for the DLX data-memory port.
// Takes one read or write at a time, completes it LATENCY cycles after
// acceptance and flags completion with a one-cycle DATA_READY pulse.
//
// state | meaning
// IDLE  | waiting for ENABLE; request latched on acceptance
// WAIT  | counting down latency; inputs ignored
// DONE  | access done; DATA_READY/ERROR valid for this cycle only
module dram_latency_model #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int DEPTH_LOG2 = 10,
    parameter int LATENCY    = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ENABLE,
    input  logic              READNOTWRITE,
    input  logic [ADDR_W-1:0] ADDRESS,
    input  logic [DATA_W-1:0] DATA_IN,
    output logic [DATA_W-1:0] DATA_OUT,
    output logic              DATA_READY,
    output logic              ERROR,
    output logic              BUSY
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam int         HI_LSB   = DEPTH_LOG2 + 2;
    localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

    if (LATENCY < 1 || LATENCY > 15) begin : g_bad_latency
        $fatal(1, "dram_latency_model: LATENCY must be in 1..15");
    end

    logic [1:0]            state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic                  rnw_q, rnw_d;
    logic [ADDR_W-1:0]     addr_q, addr_d;
    logic [DATA_W-1:0]     wdata_q, wdata_d;
    logic [DATA_W-1:0]     data_out_q, data_out_d;
    logic                  err_q, err_d;
    logic [DATA_W-1:0]     mem_q [2**DEPTH_LOG2];

    logic                  mem_we;
    logic                  addr_bad;
    logic [DEPTH_LOG2-1:0] mem_idx;

    // Decode the latched address; any bit above the array or a non-word offset is an error.
    always_comb begin
        mem_idx  = addr_q[HI_LSB-1:2];
        addr_bad = (addr_q[1:0] != 2'b00) || (|addr_q[ADDR_W-1:HI_LSB]);
    end

    // Next-state logic: accept, count down, then perform the access on the WAIT->DONE edge.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        rnw_d      = rnw_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        data_out_d = data_out_q;
        err_d      = err_q;
        mem_we     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (ENABLE) begin
                    rnw_d   = READNOTWRITE;
                    addr_d  = ADDRESS;
                    wdata_d = DATA_IN;
                    cnt_d   = CNT_LOAD;
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    state_d = ST_DONE;
                    err_d   = addr_bad;
                    if (addr_bad) begin
                        data_out_d = '0;
                    end else if (rnw_q) begin
                        data_out_d = mem_q[mem_idx];
                    end else begin
                        data_out_d = '0;
                        mem_we     = 1'b1;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Control and output registers; reset aborts any in-flight request.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= 4'd0;
            rnw_q      <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            data_out_q <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rnw_q      <= rnw_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            data_out_q <= data_out_d;
            err_q      <= err_d;
        end
    end

    // Storage array is never cleared; a write landing on a reset edge is dropped.
    always_ff @(posedge clk) begin
        if (rst && mem_we) begin
            mem_q[mem_idx] <= wdata_q;
        end
    end

    // ERROR is qualified by DONE so it reads 0 whenever DATA_READY is low.
    always_comb begin
        DATA_OUT   = data_out_q;
        DATA_READY = (state_q == ST_DONE);
        ERROR      = (state_q == ST_DONE) && err_q;
        BUSY       = (state_q != ST_IDLE);
    end

endmodule

// File: tb/tb_dram_latency_model.sv
// Bench for dram_latency_model: directed scenarios plus randomized traffic
// against a word-array reference model.
module tb_dram_latency_model;

    localparam int LAT = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        ENABLE = 1'b0;
    logic        READNOTWRITE = 1'b0;
    logic [31:0] ADDRESS = '0;
    logic [31:0] DATA_IN = '0;
    logic [31:0] DATA_OUT;
    logic        DATA_READY;
    logic        ERROR;
    logic        BUSY;

    int checks = 0;
    int errors = 0;

    logic [31:0] model_mem [1024];
    bit          written   [1024];

    dram_latency_model #(
        .ADDR_W    (32),
        .DATA_W    (32),
        .DEPTH_LOG2(10),
        .LATENCY   (LAT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .ENABLE      (ENABLE),
        .READNOTWRITE(READNOTWRITE),
        .ADDRESS     (ADDRESS),
        .DATA_IN     (DATA_IN),
        .DATA_OUT    (DATA_OUT),
        .DATA_READY  (DATA_READY),
        .ERROR       (ERROR),
        .BUSY        (BUSY)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h required %h", tag, obs, exp);
        end
    endtask

    // One full request with bounded wait; expected results come from the word-array model.
    task automatic do_req(input string tag, input logic rnw, input logic [31:0] addr,
                          input logic [31:0] wd, input bit scramble);
        logic [31:0] exp_out;
        logic        exp_err;
        int          idx;
        int          n;
        int          busy_n;
        exp_err = (addr[1:0] != 2'b00) || (addr[31:12] != 20'd0);
        idx     = int'(addr[11:2]);
        if (exp_err) begin
            exp_out = '0;
        end else if (rnw) begin
            exp_out = model_mem[idx];
        end else begin
            model_mem[idx] = wd;
            written[idx]   = 1'b1;
            exp_out        = '0;
        end
        @(negedge clk);
        ENABLE = 1'b1; READNOTWRITE = rnw; ADDRESS = addr; DATA_IN = wd;
        @(negedge clk);
        ENABLE = 1'b0;
        if (scramble) begin
            READNOTWRITE = 1'($urandom); ADDRESS = $urandom; DATA_IN = $urandom;
        end
        n = 0; busy_n = 0;
        while (DATA_READY !== 1'b1 && n < LAT + 4) begin
            if (BUSY === 1'b1) busy_n++;
            @(negedge clk);
            n++;
            if (scramble) begin
                READNOTWRITE = 1'($urandom); ADDRESS = $urandom; DATA_IN = $urandom;
            end
        end
        if (BUSY === 1'b1) busy_n++;
        check({tag, "/latency"}, 32'(n), 32'(LAT));
        check({tag, "/ready"}, {31'd0, DATA_READY}, 32'd1);
        check({tag, "/data"}, DATA_OUT, exp_out);
        check({tag, "/error"}, {31'd0, ERROR}, {31'd0, exp_err});
        @(negedge clk);
        check({tag, "/ready_low"}, {31'd0, DATA_READY}, 32'd0);
        check({tag, "/busy_low"}, {31'd0, BUSY}, 32'd0);
        check({tag, "/error_low"}, {31'd0, ERROR}, 32'd0);
        check({tag, "/data_held"}, DATA_OUT, exp_out);
        check({tag, "/busy_cycles"}, 32'(busy_n), 32'(LAT + 1));
    endtask

    initial begin
        int n;
        int t1;
        logic [31:0] a;

        // Reset state
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("rst/data_out", DATA_OUT, 32'd0);
        check("rst/ready", {31'd0, DATA_READY}, 32'd0);
        check("rst/error", {31'd0, ERROR}, 32'd0);
        check("rst/busy", {31'd0, BUSY}, 32'd0);
        rst = 1'b1;

        // Basic write then read
        do_req("wr10", 1'b0, 32'h10, 32'hDEADBEEF, 1'b0);
        do_req("rd10", 1'b1, 32'h10, 32'h0, 1'b0);

        // Error addresses: reads and writes must not touch memory
        do_req("wr0", 1'b0, 32'h0, 32'h1111_2222, 1'b0);
        do_req("rd13", 1'b1, 32'h13, 32'h0, 1'b0);
        do_req("rd1000", 1'b1, 32'h1000, 32'h0, 1'b0);
        do_req("wr13", 1'b0, 32'h13, 32'hBAD0_0001, 1'b0);
        do_req("wr1000", 1'b0, 32'h1000, 32'hBAD0_0002, 1'b0);
        do_req("wr80000000", 1'b0, 32'h8000_0010, 32'hBAD0_0003, 1'b0);
        do_req("rd10_after_err", 1'b1, 32'h10, 32'h0, 1'b0);
        do_req("rd0_after_err", 1'b1, 32'h0, 32'h0, 1'b0);

        // Reset during WAIT aborts a pending write
        do_req("wr20", 1'b0, 32'h20, 32'hA5A5_0F0F, 1'b0);
        do_req("rd20", 1'b1, 32'h20, 32'h0, 1'b0);
        @(negedge clk);
        ENABLE = 1'b1; READNOTWRITE = 1'b0; ADDRESS = 32'h20; DATA_IN = 32'h5;
        @(negedge clk);
        ENABLE = 1'b0;
        check("abort/busy_before", {31'd0, BUSY}, 32'd1);
        rst = 1'b0;
        @(negedge clk);
        check("abort/data_out", DATA_OUT, 32'd0);
        check("abort/ready", {31'd0, DATA_READY}, 32'd0);
        check("abort/error", {31'd0, ERROR}, 32'd0);
        check("abort/busy", {31'd0, BUSY}, 32'd0);
        rst = 1'b1;
        do_req("rd20_after_abort", 1'b1, 32'h20, 32'h0, 1'b0);

        // Inputs changing during WAIT are ignored
        do_req("wr40_scr", 1'b0, 32'h40, 32'h0BAD_CAFE, 1'b1);
        do_req("rd40_scr", 1'b1, 32'h40, 32'h0, 1'b1);

        // ENABLE held high through DONE: back-to-back reads of 0x0 and 0x4
        do_req("wr4", 1'b0, 32'h4, 32'h4444_5555, 1'b0);
        @(negedge clk);
        ENABLE = 1'b1; READNOTWRITE = 1'b1; ADDRESS = 32'h0;
        @(negedge clk);
        ADDRESS = 32'h4;
        n = 0;
        while (DATA_READY !== 1'b1 && n < LAT + 4) begin
            @(negedge clk);
            n++;
        end
        check("b2b/first_latency", 32'(n), 32'(LAT));
        check("b2b/first_data", DATA_OUT, model_mem[0]);
        t1 = n;
        @(negedge clk);
        n++;
        while (DATA_READY !== 1'b1 && n < t1 + LAT + 6) begin
            @(negedge clk);
            n++;
        end
        ENABLE = 1'b0;
        check("b2b/spacing", 32'(n - t1), 32'(LAT + 2));
        check("b2b/second_data", DATA_OUT, model_mem[1]);
        check("b2b/second_error", {31'd0, ERROR}, 32'd0);
        @(negedge clk);
        check("b2b/ready_low", {31'd0, DATA_READY}, 32'd0);
        check("b2b/busy_low", {31'd0, BUSY}, 32'd0);

        // Randomized traffic over a small window plus occasional bad addresses
        for (int i = 0; i < 40; i++) begin
            int idx;
            idx = int'($urandom_range(0, 15));
            if ($urandom_range(0, 7) == 0) begin
                if ($urandom_range(0, 1) == 0)
                    a = {20'd0, 10'(idx), 2'($urandom_range(1, 3))};
                else
                    a = {20'($urandom_range(1, 1048575)), 10'(idx), 2'b00};
                do_req("rand_bad", 1'($urandom), a, $urandom, 1'($urandom));
            end else if (written[idx] && $urandom_range(0, 1) == 1) begin
                do_req("rand_rd", 1'b1, 32'(idx) << 2, 32'h0, 1'($urandom));
            end else begin
                do_req("rand_wr", 1'b0, 32'(idx) << 2, $urandom, 1'($urandom));
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
